// File: rtl/conv_fc_classifier.sv
// Convolution + fully-connected classifier: each accepted KxK window yields one
// ReLU feature; NCLASS dot products over the FM*FM features pick the best class.
module conv_fc_classifier #(
    parameter int unsigned K      = 5,
    parameter int unsigned FM     = 24,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned W_W    = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned NCLASS = 10,
    localparam int unsigned CW    = $clog2(NCLASS),
    localparam int unsigned AW    = $clog2(NCLASS * FM * FM)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_win_valid,
    input  logic [K*K*PIX_W-1:0]    i_win,
    output logic                    o_win_ready,
    input  logic                    i_wld_en,
    input  logic                    i_wld_sel,
    input  logic [AW-1:0]           i_wld_addr,
    input  logic signed [W_W-1:0]   i_wld_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [CW-1:0]           o_out,
    output logic signed [ACC_W-1:0] o_out_score
);

    localparam int unsigned NWIN  = K * K;
    localparam int unsigned NFEAT = FM * FM;
    localparam int unsigned FW    = $clog2(NFEAT);
    localparam int unsigned CKW   = $clog2(NWIN);

    typedef enum logic [1:0] {StIdle, StConv, StFc, StResult} state_e;

    state_e                  r_state;
    // Weight and feature storage carries no reset so weights survive nRST
    logic signed [W_W-1:0]   r_cw   [NWIN];
    logic signed [W_W-1:0]   r_fw   [NCLASS*NFEAT];
    logic signed [ACC_W-1:0] r_feat [NFEAT];

    logic [FW-1:0]           r_win_cnt;
    logic [FW-1:0]           r_fidx;
    logic [AW-1:0]           r_fw_addr;
    logic [CW-1:0]           r_cls;
    logic                    r_cmp;
    logic signed [ACC_W-1:0] r_acc;
    logic [CW-1:0]           r_best_idx;
    logic signed [ACC_W-1:0] r_best_score;
    logic [CW-1:0]           r_out;
    logic signed [ACC_W-1:0] r_score;
    logic                    r_done;
    logic                    r_busy;
    logic                    r_ready;

    logic signed [ACC_W-1:0] w_tw;
    logic signed [ACC_W-1:0] w_tp;
    logic signed [ACC_W-1:0] w_conv_sum;
    logic signed [ACC_W-1:0] w_relu;
    logic signed [ACC_W-1:0] w_mac;
    logic                    w_accept;
    logic                    w_take;
    logic [CW-1:0]           w_best_idx;
    logic signed [ACC_W-1:0] w_best_score;

    assign w_accept    = (r_state == StConv) && i_win_valid;
    assign w_relu      = w_conv_sum[ACC_W-1] ? '0 : w_conv_sum;
    assign w_mac       = r_feat[r_fidx] * ACC_W'(r_fw[r_fw_addr]);
    // Class 0 always seeds the best; later classes must be strictly greater
    assign w_take       = (r_cls == '0) || (r_acc > r_best_score);
    assign w_best_idx   = w_take ? r_cls : r_best_idx;
    assign w_best_score = w_take ? r_acc : r_best_score;

    assign o_win_ready = r_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_out       = r_out;
    assign o_out_score = r_score;

    // Window dot product: signed weights times zero-extended pixels
    always_comb begin
        w_conv_sum = '0;
        w_tw       = '0;
        w_tp       = '0;
        for (int k = 0; k < NWIN; k++) begin
            w_tw       = ACC_W'(r_cw[k]);
            w_tp       = ACC_W'(i_win[k*PIX_W +: PIX_W]);
            w_conv_sum = w_conv_sum + w_tw * w_tp;
        end
    end

    // Weight loading (IDLE only) and feature capture on each accepted window
    always_ff @(posedge i_clk) begin
        if (r_state == StIdle && i_wld_en) begin
            if (!i_wld_sel) begin
                if (i_wld_addr < AW'(NWIN)) r_cw[i_wld_addr[CKW-1:0]] <= i_wld_data;
            end else if (i_wld_addr < AW'(NCLASS * NFEAT)) begin
                r_fw[i_wld_addr] <= i_wld_data;
            end
        end
        if (w_accept) r_feat[r_win_cnt] <= w_relu;
    end

    // Control FSM with counters, FC accumulator and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_win_cnt    <= '0;
            r_fidx       <= '0;
            r_fw_addr    <= '0;
            r_cls        <= '0;
            r_cmp        <= 1'b0;
            r_acc        <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
            r_out        <= '0;
            r_score      <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state   <= StConv;
                        r_win_cnt <= '0;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                StConv: begin
                    if (i_win_valid) begin
                        if (r_win_cnt == FW'(NFEAT - 1)) begin
                            r_state   <= StFc;
                            r_ready   <= 1'b0;
                            r_win_cnt <= '0;
                            r_fidx    <= '0;
                            r_fw_addr <= '0;
                            r_cls     <= '0;
                            r_cmp     <= 1'b0;
                            r_acc     <= '0;
                        end else begin
                            r_win_cnt <= r_win_cnt + FW'(1);
                        end
                    end
                end
                StFc: begin
                    if (!r_cmp) begin
                        // MAC phase; r_fw_addr runs continuously so it equals c*NFEAT+f
                        r_acc     <= r_acc + w_mac;
                        r_fw_addr <= r_fw_addr + AW'(1);
                        if (r_fidx == FW'(NFEAT - 1)) begin
                            r_fidx <= '0;
                            r_cmp  <= 1'b1;
                        end else begin
                            r_fidx <= r_fidx + FW'(1);
                        end
                    end else begin
                        r_cmp        <= 1'b0;
                        r_acc        <= '0;
                        r_best_idx   <= w_best_idx;
                        r_best_score <= w_best_score;
                        if (r_cls == CW'(NCLASS - 1)) begin
                            r_state <= StResult;
                            r_out   <= w_best_idx;
                            r_score <= w_best_score;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cls <= r_cls + CW'(1);
                        end
                    end
                end
                StResult: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/conv_fc_classifier.md
CONV_FC_CLASSIFIER -- requirements
Module: conv_fc_classifier

Interface
REQ-001 Parameter K, default 5, convolution kernel side; window is K*K pixels.
REQ-002 Parameter FM, default 24, feature-map side; FM*FM windows per image.
REQ-003 Parameter PIX_W, default 8, unsigned pixel width.
REQ-004 Parameter W_W, default 8, signed weight width for conv and FC weights.
REQ-005 Parameter ACC_W, default 32, signed accumulator, feature and score width.
REQ-006 Parameter NCLASS, default 10, number of FC output classes; CW = clog2(NCLASS).
REQ-007 CLK  in  1  sole clock, rising edge.
REQ-008 nRST  in  1  asynchronous, active-low reset.
REQ-009 START  in  1  begin one image; sampled only in IDLE.
REQ-010 WIN_VALID  in  1  window present on WIN.
REQ-011 WIN  in  K*K*PIX_W  window; pixel (i,j) at bits [(i*K+j)*PIX_W +: PIX_W].
REQ-012 WIN_READY  out  1  high only in CONV; a window is accepted on any edge where WIN_VALID and WIN_READY are both high.
REQ-013 WLD_EN  in  1  weight write strobe, honoured only in IDLE.
REQ-014 WLD_SEL  in  1  0 = conv weight, address i*K+j; 1 = FC weight, address c*FM*FM+f.
REQ-015 WLD_ADDR  in  clog2(NCLASS*FM*FM)  weight address.
REQ-016 WLD_DATA  in  W_W  signed weight value.
REQ-017 BUSY  out  1  high in CONV and FC.
REQ-018 DONE  out  1  one-cycle pulse when the result is valid.
REQ-019 OUT  out  CW  winning class index.
REQ-020 OUT_SCORE  out  ACC_W  winning class score.

Function
REQ-021 The block SHALL implement states IDLE, CONV, FC and RESULT: IDLE->CONV on START; CONV->FC on acceptance of window FM*FM; FC->RESULT after the final class compare; RESULT->IDLE after one cycle.
REQ-022 Each accepted window SHALL produce feature f = sum over (i,j) of signed weight times zero-extended pixel in ACC_W bits, stored at feature index f = accept count (raster order, 0..FM*FM-1).
REQ-023 A negative feature SHALL be stored as 0 (ReLU).
REQ-024 CONV SHALL tolerate WIN_VALID gaps of any length; the window counter advances only on acceptance.
REQ-025 FC SHALL spend FM*FM MAC cycles per class (one feature times one FC weight per cycle), followed by one compare cycle, in order c = 0..NCLASS-1.
REQ-026 The FC accumulator SHALL wrap in two's complement without saturation.
REQ-027 In the compare cycle, a class SHALL replace the best only if its score is strictly greater; class 0 always initialises the best, so ties resolve to the lowest index.
REQ-028 DONE, OUT and OUT_SCORE SHALL update on the final compare edge, which is NCLASS*(FM*FM+1) edges after the final window accept (5770 at defaults); OUT and OUT_SCORE SHALL hold until the next final compare or reset.
REQ-029 START in CONV, FC or RESULT SHALL be ignored; WLD_EN outside IDLE SHALL be ignored, with weights unchanged.
REQ-030 Weights SHALL persist across images and across reset.

Reset
REQ-031 nRST low SHALL force IDLE, with DONE=0, OUT=0, OUT_SCORE=0, BUSY=0, WIN_READY=0 and all counters cleared, asynchronously and at any state including mid-CONV or mid-FC.
REQ-032 The first image after reset SHALL require a fresh START; no partial result is ever reported.

Verification
REQ-033 Defaults; all conv weights 1, all pixels 1; FC class 3 weights 1, others 0 -> every feature 25; OUT=3, OUT_SCORE=14400, DONE high for exactly one cycle.
REQ-034 All conv weights -1, any pixels -> features 0, all scores 0 -> OUT=0, OUT_SCORE=0.
REQ-035 As REQ-033, but classes 2 and 7 both have weights 1 -> OUT=2 (tie goes to the lowest index).
REQ-036 Random WIN_VALID gaps, then count edges from the final accept -> DONE rises exactly 5770 edges later; BUSY stays high throughout CONV and FC.
REQ-037 nRST pulsed mid-FC, then START with no weight reload and the REQ-033 stimulus -> outputs zero during reset, then OUT=3, OUT_SCORE=14400.
REQ-038 START and WLD_EN (conv weight address 0 set to 5) asserted during CONV -> no restart, no weight change, result identical to REQ-033.
